line_arb: RTL and testbench

LINE_ARB -- requirements
Module: line_arb

---
 rtl/line_arb.sv | 208 ++++++++++++++++++++
 tb/tb_line_arb.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_arb.sv
// line_arb: round-robin arbiter that serialises cache line fills and
// writebacks from NCH ports onto a single quad-SPI bus (one nibble per cycle).
module line_arb #(
  parameter int unsigned NCH         = 2,
  parameter int unsigned PA          = 22,
  parameter int unsigned LINE_LENGTH = 4,
  parameter int unsigned DUMMY       = 4
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic [NCH-1:0]                             req,
  input  logic [NCH-1:0]                             write,
  input  logic [NCH-1:0]                             mem,
  input  logic [NCH*(PA-$clog2(LINE_LENGTH))-1:0]    tag,
  input  logic [NCH*4-1:0]                           wdata,
  input  logic [3:0]                                 dread,
  output logic [NCH-1:0]                             grant,
  output logic [NCH-1:0]                             rstrobe,
  output logic [NCH-1:0]                             wnext,
  output logic [NCH-1:0]                             done,
  output logic                                       err,
  output logic [3:0]                                 uio_out,
  output logic [3:0]                                 uio_oe,
  output logic [1:0]                                 cs
);

  localparam int unsigned LB = $clog2(LINE_LENGTH);
  localparam int unsigned TW = PA - LB;
  localparam int unsigned PW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [15:0] DUMMY_LAST = 16'((DUMMY > 0) ? DUMMY - 1 : 0);
  localparam logic [15:0] DATA_LAST  = 16'(2 * LINE_LENGTH - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DUMMY,
    ST_DATA,
    ST_DONE
  } state_t;

  state_t          state, state_nx;
  logic [15:0]     cnt, cnt_nx;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   win, idx, win_q;
  logic            found;
  logic [NCH-1:0]  win_oh;
  logic            reject;
  logic            arb_fire;
  logic [NCH-1:0]  grant_q;
  logic            mem_q;
  logic            write_q;
  logic [TW-1:0]   tag_q;
  logic            err_q;
  logic [NCH-1:0]  rej_done_q;
  logic [TW-1:0]   tag_arr   [NCH];
  logic [3:0]      wdata_arr [NCH];
  logic [PA-1:0]   line_addr;
  logic [23:0]     addr24;
  logic [23:0]     addr_sh;
  logic [7:0]      cmd_byte;
  logic [1:0]      cs_sel;

  // Read data is sampled by the granted channel directly off the bus.
  logic unused_dread;
  assign unused_dread = ^dread;

  // Split the packed per-channel buses into indexable arrays.
  always_comb begin
    for (int unsigned k = 0; k < NCH; k++) begin
      tag_arr[k]   = tag[k*TW +: TW];
      wdata_arr[k] = wdata[k*4 +: 4];
    end
  end

  // Round-robin search starting at ptr; first requesting channel wins.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      idx = PW'((32'(ptr) + i) % NCH);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign win_oh   = NCH'(1) << win;
  assign reject   = write[win] && !mem[win];
  // Arbitration pauses for the cycle carrying a rejection pulse so the
  // rejected channel can drop its request before being looked at again.
  assign arb_fire = (state == ST_IDLE) && found && !err_q;

  assign line_addr = {tag_q, {LB{1'b0}}};
  assign addr24    = 24'(line_addr);
  assign addr_sh   = addr24 << {cnt[2:0], 2'b00};
  assign cmd_byte  = write_q ? 8'h38 : 8'hEB;
  assign cs_sel    = mem_q ? 2'b01 : 2'b10;

  // State register, beat counter, round-robin pointer and latched request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      ptr        <= '0;
      win_q      <= '0;
      grant_q    <= '0;
      mem_q      <= 1'b0;
      write_q    <= 1'b0;
      tag_q      <= '0;
      err_q      <= 1'b0;
      rej_done_q <= '0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      err_q      <= 1'b0;
      rej_done_q <= '0;
      if (arb_fire) begin
        ptr <= PW'((32'(win) + 1) % NCH);
        if (reject) begin
          err_q      <= 1'b1;
          rej_done_q <= win_oh;
        end else begin
          win_q   <= win;
          grant_q <= win_oh;
          mem_q   <= mem[win];
          write_q <= write[win];
          tag_q   <= tag_arr[win];
        end
      end
    end
  end

  // Next-state sequencing and bus/handshake outputs decoded from state.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt + 16'd1;
    grant    = '0;
    rstrobe  = '0;
    wnext    = '0;
    done     = rej_done_q;
    err      = err_q;
    cs       = 2'b11;
    uio_oe   = '0;
    uio_out  = '0;
    case (state)
      ST_IDLE: begin
        cnt_nx = '0;
        if (arb_fire && !reject) state_nx = ST_CMD;
      end
      ST_CMD: begin
        grant   = grant_q;
        cs      = cs_sel;
        uio_oe  = '1;
        uio_out = cnt[0] ? cmd_byte[3:0] : cmd_byte[7:4];
        if (cnt == 16'd1) begin
          state_nx = ST_ADDR;
          cnt_nx   = '0;
        end
      end
      ST_ADDR: begin
        grant   = grant_q;
        cs      = cs_sel;
        uio_oe  = '1;
        uio_out = addr_sh[23:20];
        if (cnt == 16'd5) begin
          state_nx = (write_q || DUMMY == 0) ? ST_DATA : ST_DUMMY;
          cnt_nx   = '0;
        end
      end
      ST_DUMMY: begin
        grant = grant_q;
        cs    = cs_sel;
        if (cnt == DUMMY_LAST) begin
          state_nx = ST_DATA;
          cnt_nx   = '0;
        end
      end
      ST_DATA: begin
        grant = grant_q;
        cs    = cs_sel;
        if (write_q) begin
          wnext   = grant_q;
          uio_oe  = '1;
          uio_out = wdata_arr[win_q];
        end else begin
          rstrobe = grant_q;
        end
        if (cnt == DATA_LAST) begin
          state_nx = ST_DONE;
          cnt_nx   = '0;
        end
      end
      ST_DONE: begin
        done     = grant_q;
        state_nx = ST_IDLE;
        cnt_nx   = '0;
      end
      default: begin
        state_nx = ST_IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_line_arb.sv
// tb_line_arb: vector table plus hand-written sequences for line_arb,
// including a second instance with 16-byte lines, no dummy and 4 channels.
module tb_line_arb;

  localparam int unsigned DUMMY_A = 4;
  localparam int unsigned LL_A    = 4;

  logic        clk;
  logic        reset;
  logic [1:0]  req, write, mem;
  logic [39:0] tag;
  logic [7:0]  wdata;
  logic [3:0]  dread;
  logic [1:0]  grant, rstrobe, wnext, done;
  logic        err;
  logic [3:0]  uio_out, uio_oe;
  logic [1:0]  cs;

  logic [3:0]  req_b, write_b, mem_b;
  logic [71:0] tag_b;
  logic [15:0] wdata_b;
  logic [3:0]  grant_b, rstrobe_b, wnext_b, done_b;
  logic        err_b;
  logic [3:0]  uio_out_b, uio_oe_b;
  logic [1:0]  cs_b;

  int checks = 0;
  int errors = 0;

  line_arb dut (
    .clk(clk), .reset(reset), .req(req), .write(write), .mem(mem), .tag(tag),
    .wdata(wdata), .dread(dread), .grant(grant), .rstrobe(rstrobe), .wnext(wnext),
    .done(done), .err(err), .uio_out(uio_out), .uio_oe(uio_oe), .cs(cs)
  );

  line_arb #(.NCH(4), .PA(22), .LINE_LENGTH(16), .DUMMY(0)) dut_b (
    .clk(clk), .reset(reset), .req(req_b), .write(write_b), .mem(mem_b), .tag(tag_b),
    .wdata(wdata_b), .dread(dread), .grant(grant_b), .rstrobe(rstrobe_b), .wnext(wnext_b),
    .done(done_b), .err(err_b), .uio_out(uio_out_b), .uio_oe(uio_oe_b), .cs(cs_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] cs;
    logic [3:0] oe;
    logic [3:0] out;
    logic [1:0] grant;
    logic [1:0] rstrobe;
    logic [1:0] wnext;
    logic [1:0] done;
    logic       err;
  } obs_t;

  typedef struct {
    string       name;
    int unsigned ch;
    logic        wr;
    logic        mem;
    logic [19:0] tag;
    logic        rej;
    logic [1:0]  cs;
    logic [7:0]  cmd;
    logic [23:0] addr;
  } vec_t;

  vec_t vecs [6];
  vec_t vec_after_reset;

  function automatic obs_t mk(input logic [1:0] c, input logic [3:0] oe, input logic [3:0] o,
                              input logic [1:0] g, input logic [1:0] r, input logic [1:0] w,
                              input logic [1:0] d, input logic e);
    obs_t x;
    x.cs = c; x.oe = oe; x.out = o; x.grant = g;
    x.rstrobe = r; x.wnext = w; x.done = d; x.err = e;
    return x;
  endfunction

  function automatic obs_t sample();
    return mk(cs, uio_oe, uio_out, grant, rstrobe, wnext, done, err);
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Pushes the expected per-cycle bus trace for one request, then drives the
  // request and pops/compares one record per clock.
  task automatic run_vec(input vec_t v);
    obs_t        q[$];
    obs_t        e, got;
    logic [1:0]  oh;
    logic [23:0] a;
    int unsigned cyc;
    oh = 2'b01 << v.ch;
    a  = v.addr;
    if (v.rej) begin
      q.push_back(mk(2'b11, 4'h0, 4'h0, 2'b00, 2'b00, 2'b00, oh, 1'b1));
    end else begin
      q.push_back(mk(v.cs, 4'hF, v.cmd[7:4], oh, 2'b00, 2'b00, 2'b00, 1'b0));
      q.push_back(mk(v.cs, 4'hF, v.cmd[3:0], oh, 2'b00, 2'b00, 2'b00, 1'b0));
      for (int i = 0; i < 6; i++) begin
        q.push_back(mk(v.cs, 4'hF, a[23:20], oh, 2'b00, 2'b00, 2'b00, 1'b0));
        a = a << 4;
      end
      if (!v.wr)
        for (int i = 0; i < DUMMY_A; i++)
          q.push_back(mk(v.cs, 4'h0, 4'h0, oh, 2'b00, 2'b00, 2'b00, 1'b0));
      for (int i = 0; i < 2 * LL_A; i++) begin
        if (v.wr) q.push_back(mk(v.cs, 4'hF, 4'(i + 1), oh, 2'b00, oh, 2'b00, 1'b0));
        else      q.push_back(mk(v.cs, 4'h0, 4'h0, oh, oh, 2'b00, 2'b00, 1'b0));
      end
      q.push_back(mk(2'b11, 4'h0, 4'h0, 2'b00, 2'b00, 2'b00, oh, 1'b0));
    end
    q.push_back(mk(2'b11, 4'h0, 4'h0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0));

    tag[v.ch*20 +: 20] = v.tag;
    write[v.ch] = v.wr;
    mem[v.ch]   = v.mem;
    wdata       = '0;
    req[v.ch]   = 1'b1;
    cyc = 0;
    while (q.size() > 0) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 1) req[v.ch] = 1'b0;
      if (cyc == 2) begin
        write[v.ch] = ~v.wr;
        mem[v.ch]   = ~v.mem;
        tag[v.ch*20 +: 20] = ~v.tag;
      end
      wdata[v.ch*4 +: 4] = (cyc >= 9 && cyc <= 16) ? 4'(cyc - 8) : 4'h0;
      #1;
      got = sample();
      e   = q.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL %s cycle %0d: got %h expected %h", v.name, cyc, got, e);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned zeros, len, w, lead, cnt, bad;
    logic [1:0] exp_g;

    vecs[0] = '{"rd_ch0_ram",   0, 1'b0, 1'b1, 20'h12345, 1'b0, 2'b01, 8'hEB, 24'h048D14};
    vecs[1] = '{"wr_ch1_ram",   1, 1'b1, 1'b1, 20'h00ABC, 1'b0, 2'b01, 8'h38, 24'h002AF0};
    vecs[2] = '{"rd_ch0_rom",   0, 1'b0, 1'b0, 20'hFFFFF, 1'b0, 2'b10, 8'hEB, 24'h3FFFFC};
    vecs[3] = '{"wr_ch1_rom",   1, 1'b1, 1'b0, 20'h00123, 1'b1, 2'b11, 8'h00, 24'h000000};
    vecs[4] = '{"rd_ch1_rom",   1, 1'b0, 1'b0, 20'h00001, 1'b0, 2'b10, 8'hEB, 24'h000004};
    vecs[5] = '{"wr_ch0_ram",   0, 1'b1, 1'b1, 20'h80000, 1'b0, 2'b01, 8'h38, 24'h200000};
    vec_after_reset = '{"rd_ch1_post_reset", 1, 1'b0, 1'b1, 20'h00010, 1'b0, 2'b01, 8'hEB, 24'h000040};

    reset = 1'b0;
    req = '0; write = '0; mem = '0; tag = '0; wdata = '0; dread = 4'hA;
    req_b = '0; write_b = '0; mem_b = '0; tag_b = '0; wdata_b = '0;
    repeat (3) @(posedge clk);
    #2;
    check("reset_state", 32'(sample()), 32'(mk(2'b11, 4'h0, 4'h0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0)));
    check("reset_state_b", {24'd0, grant_b, done_b}, 32'd0);
    reset = 1'b1;

    // Both channels held: first grant after reset is channel 0, then alternates.
    @(posedge clk); #1;
    mem = 2'b11; write = 2'b00; tag = {20'h00040, 20'h00020};
    req = 2'b11;
    #1;
    for (int n = 0; n < 4; n++) begin
      zeros = 0;
      while (grant == 2'b00 && zeros < 50) begin
        zeros++;
        @(posedge clk); #2;
      end
      exp_g = (n % 2 == 1) ? 2'b10 : 2'b01;
      check("rr_grant", 32'(grant), 32'(exp_g));
      if (n > 0) check("rr_gap", zeros, 32'd2);
      len = 0;
      while (grant != 2'b00 && len < 50) begin
        len++;
        @(posedge clk); #2;
      end
      check("rr_len", len, 32'd20);
      check("rr_done", 32'(done), 32'(exp_g));
      if (n == 3) req = 2'b00;
    end
    @(posedge clk); #2;
    @(posedge clk); #2;
    check("rr_quiet", {28'd0, cs, grant}, {28'd0, 2'b11, 2'b00});

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Reset during a read: bus released immediately, no completion pulse.
    @(posedge clk); #1;
    tag[19:0] = 20'h12345; write[0] = 1'b0; mem[0] = 1'b1;
    req = 2'b01;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #2;
      if (c == 1) req = 2'b00;
    end
    check("pre_reset_cs", 32'(cs), 32'(2'b01));
    reset = 1'b0;
    #1;
    check("async_reset_bus", {20'd0, cs, uio_oe, uio_out, grant}, {20'd0, 2'b11, 4'h0, 4'h0, 2'b00});
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #2;
      check("reset_no_done", {28'd0, done, cs}, {28'd0, 2'b00, 2'b11});
    end
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    run_vec(vec_after_reset);

    // Wide-line, zero-dummy, four-channel instance.
    @(posedge clk); #1;
    mem_b = 4'hF; write_b = 4'h0; tag_b = '0;
    req_b = 4'hF;
    #1;
    for (int n = 0; n < 4; n++) begin
      w = 0;
      while (grant_b == 4'h0 && w < 100) begin
        w++;
        @(posedge clk); #2;
      end
      check("b_grant", 32'(grant_b), 32'(4'b0001 << n));
      lead = 0;
      while (grant_b != 4'h0 && rstrobe_b == 4'h0 && lead < 100) begin
        lead++;
        @(posedge clk); #2;
      end
      check("b_cmd_addr_len", lead, 32'd8);
      cnt = 0; bad = 0;
      while (rstrobe_b != 4'h0 && cnt < 100) begin
        cnt++;
        if (uio_oe_b != 4'h0 || uio_out_b != 4'h0 || cs_b != 2'b01 || wnext_b != 4'h0) bad++;
        @(posedge clk); #2;
      end
      check("b_data_len", cnt, 32'd32);
      check("b_data_bus", bad, 32'd0);
      check("b_done", 32'(done_b), 32'(4'b0001 << n));
      check("b_done_bus", {29'd0, cs_b, err_b}, {29'd0, 2'b11, 1'b0});
      if (n == 3) req_b = 4'h0;
    end

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
